// File: rtl/pinwheel_operand_fetch.sv
// Operand-fetch stage of the pinwheel barrel core.
// Maps {tid, rs} onto the dual-port regfile read addresses, absorbs the one-cycle
// RAM read latency in stage register S1, and routes writeback to the write port.
// Optional feature macro: PINWHEEL_OPFETCH_BYPASS_EN (same-edge writeback forwarding).
module pinwheel_operand_fetch #(
  parameter int unsigned reg_count    = 32,
  parameter int unsigned reg_width    = 32,
  parameter int unsigned thread_count = 4,
  localparam int unsigned reg_bits    = $clog2(reg_count),
  localparam int unsigned tid_bits    = $clog2(thread_count),
  localparam int unsigned addr_bits   = reg_bits + tid_bits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // issue side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [tid_bits-1:0]  in_tid,
  input  logic [reg_bits-1:0]  in_rs1,
  input  logic [reg_bits-1:0]  in_rs2,
  input  logic [31:0]          in_pc,
  // operand output
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [tid_bits-1:0]  out_tid,
  output logic [31:0]          out_pc,
  output logic [reg_width-1:0] out_rs1_data,
  output logic [reg_width-1:0] out_rs2_data,
  // writeback
  input  logic                 wb_valid,
  input  logic [tid_bits-1:0]  wb_tid,
  input  logic [reg_bits-1:0]  wb_rd,
  input  logic [reg_width-1:0] wb_data,
  // regfile ports
  output logic [addr_bits-1:0] raddr0,
  output logic [addr_bits-1:0] raddr1,
  input  logic [reg_width-1:0] rdata0,
  input  logic [reg_width-1:0] rdata1,
  output logic [addr_bits-1:0] waddr,
  output logic [reg_width-1:0] wdata,
  output logic                 wren
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic                 s1_valid;
  logic [tid_bits-1:0]  s1_tid;
  logic [31:0]          s1_pc;
  logic [reg_bits-1:0]  s1_rs1;
  logic [reg_bits-1:0]  s1_rs2;
  logic [addr_bits-1:0] raddr0_q;
  logic [addr_bits-1:0] raddr1_q;
  logic                 accept;
  logic                 read_issued;
  logic [reg_width-1:0] op0_raw;
  logic [reg_width-1:0] op1_raw;

  assign s1_valid    = (state_q == StFull);
  // Held low during reset so nothing is accepted (and raddr stays 0) until release.
  assign in_ready    = rst_n && (!s1_valid || out_ready);
  assign accept      = in_valid && in_ready;
  // Every edge with an accept or a held entry issues a RAM read.
  assign read_issued = accept || s1_valid;

  // Next-state logic for the S1 occupancy FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (accept)         state_d = StFull;
        else if (out_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // S1 occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // S1 payload loads on accept; cleared by reset so operands read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tid <= '0;
      s1_pc  <= '0;
      s1_rs1 <= '0;
      s1_rs2 <= '0;
    end else if (accept) begin
      s1_tid <= in_tid;
      s1_pc  <= in_pc;
      s1_rs1 <= in_rs1;
      s1_rs2 <= in_rs2;
    end
  end

  // Read addresses: new instruction on accept, re-read of S1 while held, else hold.
  always_comb begin
    raddr0 = raddr0_q;
    raddr1 = raddr1_q;
    if (accept) begin
      raddr0 = {in_tid, in_rs1};
      raddr1 = {in_tid, in_rs2};
    end else if (s1_valid) begin
      raddr0 = {s1_tid, s1_rs1};
      raddr1 = {s1_tid, s1_rs2};
    end
  end

  // Remember the last presented address so an idle stage keeps it stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr0_q <= '0;
      raddr1_q <= '0;
    end else begin
      raddr0_q <= raddr0;
      raddr1_q <= raddr1;
    end
  end

  // Write port: x0 writes are dropped and nothing is written while in reset.
  always_comb begin
    wren  = wb_valid && (wb_rd != '0) && rst_n;
    waddr = rst_n ? {wb_tid, wb_rd} : '0;
    wdata = wb_data;
  end

`ifdef PINWHEEL_OPFETCH_BYPASS_EN
  logic                 byp0_q, byp1_q;
  logic [reg_width-1:0] bdata0_q, bdata1_q;
  logic                 match0, match1;

  // RAM returns old data on read-during-write, so capture the write on that edge.
  assign match0 = wren && (waddr == raddr0);
  assign match1 = wren && (waddr == raddr1);

  // Bypass flags follow every issued read; a re-read without a match clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp0_q   <= 1'b0;
      byp1_q   <= 1'b0;
      bdata0_q <= '0;
      bdata1_q <= '0;
    end else if (read_issued) begin
      byp0_q <= match0;
      byp1_q <= match1;
      if (match0) bdata0_q <= wdata;
      if (match1) bdata1_q <= wdata;
    end
  end

  // Pick forwarded data over the RAM result when flagged.
  always_comb begin
    op0_raw = byp0_q ? bdata0_q : rdata0;
    op1_raw = byp1_q ? bdata1_q : rdata1;
  end
`else
  logic unused_read_issued;
  assign unused_read_issued = read_issued;

  // Without forwarding the operands come straight from the RAM.
  always_comb begin
    op0_raw = rdata0;
    op1_raw = rdata1;
  end
`endif

  // Output mux: x0 always reads as zero.
  always_comb begin
    out_valid    = s1_valid;
    out_tid      = s1_tid;
    out_pc       = s1_pc;
    out_rs1_data = (s1_rs1 == '0) ? '0 : op0_raw;
    out_rs2_data = (s1_rs2 == '0) ? '0 : op1_raw;
  end

endmodule

// File: tb/tb_pinwheel_operand_fetch.sv
// Directed bench for pinwheel_operand_fetch with a registered-read regfile model.
module tb_pinwheel_operand_fetch;

  localparam int unsigned RW = 32;
  localparam int unsigned TB = 2;
  localparam int unsigned RB = 5;
  localparam int unsigned AB = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [TB-1:0] in_tid;
  logic [RB-1:0] in_rs1, in_rs2;
  logic [31:0]   in_pc;
  logic          out_valid, out_ready;
  logic [TB-1:0] out_tid;
  logic [31:0]   out_pc;
  logic [RW-1:0] out_rs1_data, out_rs2_data;
  logic          wb_valid;
  logic [TB-1:0] wb_tid;
  logic [RB-1:0] wb_rd;
  logic [RW-1:0] wb_data;
  logic [AB-1:0] raddr0, raddr1, waddr;
  logic [RW-1:0] rdata0, rdata1, wdata;
  logic          wren;

  int passed = 0;
  int total  = 0;

  logic [RW-1:0] mem [0:(1<<AB)-1];

  always #5 clk = ~clk;

  // Regfile model: registered read, old data on read-during-write.
  always @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
  end

  pinwheel_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .wb_valid(wb_valid), .wb_tid(wb_tid), .wb_rd(wb_rd), .wb_data(wb_data),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .waddr(waddr), .wdata(wdata), .wren(wren)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [TB-1:0] t, input logic [RB-1:0] r, input logic [RW-1:0] d);
    wb_valid = 1'b1; wb_tid = t; wb_rd = r; wb_data = d;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic drive_in(input logic [TB-1:0] t, input logic [RB-1:0] r1, input logic [RB-1:0] r2,
                          input logic [31:0] pc);
    in_valid = 1'b1; in_tid = t; in_rs1 = r1; in_rs2 = r2; in_pc = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_in(2'd2, 5'd5, 5'd6, 32'h99);
    wb_valid = 1'b1; wb_tid = 2'd1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %h exp 0", out_valid); else passed++;
    total++; if (out_tid !== 2'd0) $display("FAIL rst_out_tid got %h exp 0", out_tid); else passed++;
    total++; if (out_pc !== 32'd0) $display("FAIL rst_out_pc got %h exp 0", out_pc); else passed++;
    total++; if (out_rs1_data !== 32'd0) $display("FAIL rst_rs1 got %h exp 0", out_rs1_data); else passed++;
    total++; if (wren !== 1'b0) $display("FAIL rst_wren got %h exp 0", wren); else passed++;
    total++; if (waddr !== 7'd0) $display("FAIL rst_waddr got %h exp 0", waddr); else passed++;
    step();
    total++; if (raddr0 !== 7'd0) $display("FAIL rst_raddr0 got %h exp 0", raddr0); else passed++;
    total++; if (raddr1 !== 7'd0) $display("FAIL rst_raddr1 got %h exp 0", raddr1); else passed++;
    in_valid = 1'b0; wb_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %h exp 1", in_ready); else passed++;
    step();
  endtask

  task automatic test_basic();
    wb_write(2'd2, 5'd5, 32'h1234);
    out_ready = 1'b1;
    drive_in(2'd2, 5'd5, 5'd0, 32'h100);
    #1;
    total++; if (raddr0 !== 7'h45) $display("FAIL basic_raddr0 got %h exp 45", raddr0); else passed++;
    total++; if (raddr1 !== 7'h40) $display("FAIL basic_raddr1 got %h exp 40", raddr1); else passed++;
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %h exp 1", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'h1234) $display("FAIL basic_rs1 got %h exp 1234", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'h0) $display("FAIL basic_rs2 got %h exp 0", out_rs2_data); else passed++;
    total++; if (out_tid !== 2'd2) $display("FAIL basic_tid got %h exp 2", out_tid); else passed++;
    total++; if (out_pc !== 32'h100) $display("FAIL basic_pc got %h exp 100", out_pc); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %h exp 0", out_valid); else passed++;
  endtask

  task automatic test_x0_write();
    wb_valid = 1'b1; wb_tid = 2'd1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    #1;
    total++; if (wren !== 1'b0) $display("FAIL x0_wren got %h exp 0", wren); else passed++;
    step();
    wb_rd = 5'd4;
    #1;
    total++; if (wren !== 1'b1) $display("FAIL x0_wren_nonzero got %h exp 1", wren); else passed++;
    total++; if (waddr !== 7'h24) $display("FAIL x0_waddr got %h exp 24", waddr); else passed++;
    step();
    wb_valid = 1'b0;
    drive_in(2'd1, 5'd0, 5'd4, 32'h180);
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_rs1_data !== 32'h0) $display("FAIL x0_read got %h exp 0", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'hFFFF) $display("FAIL x0_rs2 got %h exp ffff", out_rs2_data); else passed++;
    step();
  endtask

  task automatic test_forward();
    logic [RW-1:0] exp_v;
`ifdef PINWHEEL_OPFETCH_BYPASS_EN
    exp_v = 32'hABCD;
`else
    exp_v = 32'h1111;
`endif
    wb_write(2'd3, 5'd7, 32'h1111);
    drive_in(2'd3, 5'd7, 5'd7, 32'h700);
    wb_valid = 1'b1; wb_tid = 2'd3; wb_rd = 5'd7; wb_data = 32'hABCD;
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    #1;
    total++; if (out_rs1_data !== exp_v) $display("FAIL fwd_rs1 got %h exp %h", out_rs1_data, exp_v); else passed++;
    total++; if (out_rs2_data !== exp_v) $display("FAIL fwd_rs2 got %h exp %h", out_rs2_data, exp_v); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [TB-1:0] tids [4];
    logic [RB-1:0] rs1s [4];
    logic [RW-1:0] exps [4];
    tids = '{2'd2, 2'd1, 2'd3, 2'd0};
    rs1s = '{5'd5, 5'd0, 5'd7, 5'd0};
    exps = '{32'h1234, 32'h0, 32'hABCD, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_in(tids[i], rs1s[i], 5'd0, 32'h200 + 32'(4 * i));
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d got %h exp 1", i, in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid%0d got %h exp 1", i, out_valid); else passed++;
      total++; if (out_tid !== tids[i]) $display("FAIL b2b_tid%0d got %h exp %h", i, out_tid, tids[i]); else passed++;
      total++; if (out_pc !== 32'h200 + 32'(4 * i))
        $display("FAIL b2b_pc%0d got %h exp %h", i, out_pc, 32'h200 + 32'(4 * i)); else passed++;
      total++; if (out_rs1_data !== exps[i])
        $display("FAIL b2b_rs1%0d got %h exp %h", i, out_rs1_data, exps[i]); else passed++;
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %h exp 0", out_valid); else passed++;
  endtask

  task automatic test_stall();
    wb_write(2'd1, 5'd9, 32'h5555);
    out_ready = 1'b0;
    drive_in(2'd1, 5'd9, 5'd0, 32'h300);
    step();
    drive_in(2'd0, 5'd0, 5'd0, 32'h400);
    wb_valid = 1'b1; wb_tid = 2'd1; wb_rd = 5'd9; wb_data = 32'h7777;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL stall_valid got %h exp 1", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'h5555) $display("FAIL stall_rs1_old got %h exp 5555", out_rs1_data); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %h exp 0", in_ready); else passed++;
    total++; if (raddr0 !== 7'h29) $display("FAIL stall_raddr0 got %h exp 29", raddr0); else passed++;
    step();
    wb_valid = 1'b0;
    #1;
    total++; if (out_pc !== 32'h300) $display("FAIL stall_pc got %h exp 300", out_pc); else passed++;
    total++; if (out_tid !== 2'd1) $display("FAIL stall_tid got %h exp 1", out_tid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready2 got %h exp 0", in_ready); else passed++;
`ifdef PINWHEEL_OPFETCH_BYPASS_EN
    total++; if (out_rs1_data !== 32'h7777) $display("FAIL stall_bypass got %h exp 7777", out_rs1_data); else passed++;
`endif
    step();
    total++; if (out_rs1_data !== 32'h7777) $display("FAIL stall_reread got %h exp 7777", out_rs1_data); else passed++;
    total++; if (out_pc !== 32'h300) $display("FAIL stall_pc2 got %h exp 300", out_pc); else passed++;
    step();
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release got %h exp 1", in_ready); else passed++;
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_pc !== 32'h400) $display("FAIL stall_next_pc got %h exp 400", out_pc); else passed++;
    total++; if (out_tid !== 2'd0) $display("FAIL stall_next_tid got %h exp 0", out_tid); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL stall_next_valid got %h exp 1", out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL stall_drain got %h exp 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_in(2'd2, 5'd5, 5'd0, 32'h500);
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL rmid_full got %h exp 1", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'h1234) $display("FAIL rmid_rs1 got %h exp 1234", out_rs1_data); else passed++;
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_tid = 2'd2; wb_rd = 5'd3; wb_data = 32'h9;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %h exp 0", out_valid); else passed++;
    total++; if (wren !== 1'b0) $display("FAIL rmid_wren got %h exp 0", wren); else passed++;
    total++; if (out_pc !== 32'h0) $display("FAIL rmid_pc got %h exp 0", out_pc); else passed++;
    total++; if (out_rs1_data !== 32'h0) $display("FAIL rmid_rs1z got %h exp 0", out_rs1_data); else passed++;
    step();
    step();
    rst_n = 1'b1; wb_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %h exp 1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_stale got %h exp 0", out_valid); else passed++;
    drive_in(2'd1, 5'd9, 5'd0, 32'h600);
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL rmid_next_valid got %h exp 1", out_valid); else passed++;
    total++; if (out_pc !== 32'h600) $display("FAIL rmid_next_pc got %h exp 600", out_pc); else passed++;
    total++; if (out_tid !== 2'd1) $display("FAIL rmid_next_tid got %h exp 1", out_tid); else passed++;
    total++; if (out_rs1_data !== 32'h7777) $display("FAIL rmid_next_rs1 got %h exp 7777", out_rs1_data); else passed++;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_tid = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_tid = '0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_basic();
    test_x0_write();
    test_forward();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
